// File: rtl/stack_stream_reverser.sv
// Frame reverser: pushes each input beat onto an external LIFO stack, then
// drains it with top/pop pairs and emits the words in reverse order.
module stack_stream_reverser #(
    parameter int BITWIDTH  = 8,
    parameter int STACKSIZE = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [BITWIDTH-1:0]         s_data,
    input  logic                        s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [BITWIDTH-1:0]         m_data,
    output logic                        m_last,
    output logic                        overflow_err,
    output logic                        stk_enable,
    output logic                        stk_push,
    output logic                        stk_pop,
    output logic                        stk_top,
    output logic [BITWIDTH-1:0]         stk_data_in,
    input  logic [BITWIDTH-1:0]         stk_data_out,
    input  logic                        stk_overflow,
    input  logic                        stk_is_empty,
    output logic [1:0]                  dbg_state,
    output logic [$clog2(STACKSIZE):0]  dbg_depth
);

    localparam int CW = $clog2(STACKSIZE) + 1;
    localparam logic [CW-1:0] FULL = CW'(STACKSIZE);

    // Both streams use valid/ready: a beat transfers on the rising edge where
    // valid && ready; the source holds data/last stable while valid && !ready.
    typedef enum logic [1:0] {
        FILL    = 2'd0,
        TOP_REQ = 2'd1,
        LOAD    = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         depth_cnt_q, depth_cnt_d;
    logic [BITWIDTH-1:0]   m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic                  overflow_err_q, overflow_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FILL;
            depth_cnt_q    <= '0;
            m_data_q       <= '0;
            m_last_q       <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            depth_cnt_q    <= depth_cnt_d;
            m_data_q       <= m_data_d;
            m_last_q       <= m_last_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        depth_cnt_d    = depth_cnt_q;
        m_data_d       = m_data_q;
        m_last_d       = m_last_q;
        overflow_err_d = overflow_err_q;
        s_ready        = 1'b0;
        m_valid        = 1'b0;
        stk_push       = 1'b0;
        stk_pop        = 1'b0;
        stk_top        = 1'b0;
        stk_data_in    = '0;
        case (state_q)
            FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    // A beat arriving while the stack is full is dropped, not pushed.
                    if (depth_cnt_q != FULL && !stk_overflow) begin
                        stk_push    = 1'b1;
                        stk_data_in = s_data;
                        depth_cnt_d = depth_cnt_q + 1'b1;
                    end else begin
                        overflow_err_d = 1'b1;
                    end
                    if (s_last) state_d = TOP_REQ;
                end
            end
            TOP_REQ: begin
                if (depth_cnt_q == '0) begin
                    overflow_err_d = 1'b0;
                    state_d        = FILL;
                end else begin
                    stk_top = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                m_data_d    = stk_data_out;
                m_last_d    = (depth_cnt_q == CW'(1));
                stk_pop     = 1'b1;
                depth_cnt_d = depth_cnt_q - 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    if (m_last_q) begin
                        m_last_d       = 1'b0;
                        overflow_err_d = 1'b0;
                        state_d        = FILL;
                    end else begin
                        state_d = TOP_REQ;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign stk_enable   = stk_push | stk_pop | stk_top;
    assign m_data       = m_data_q;
    assign m_last       = m_last_q;
    assign overflow_err = overflow_err_q;
    assign dbg_state    = state_q;
    assign dbg_depth    = depth_cnt_q;

    // The local depth count must track the attached stack's flags exactly.
    a_cmd_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0({stk_push, stk_pop, stk_top}));
    a_empty_match: assert property (@(posedge clk) disable iff (rst)
        stk_is_empty == (depth_cnt_q == '0));
    a_full_match: assert property (@(posedge clk) disable iff (rst)
        stk_overflow == (depth_cnt_q == FULL));

endmodule
